// File: rtl/me_host_cmd_bridge.sv
// me_host_cmd_bridge: sequences host param-register commands onto the
// motion-estimator core and frame memory; result/status on ledr_out.
module me_host_cmd_bridge #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [31:0]       param1_in,
    input  logic [31:0]       param2_in,
    input  logic [31:0]       param3_in,
    input  logic [11:0]       key_sw_in,
    output logic [63:0]       ledr_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              me_start,
    output logic [15:0]       me_blk_x,
    output logic [15:0]       me_blk_y,
    output logic [7:0]        me_range,
    input  logic              me_done,
    input  logic [7:0]        me_mv_x,
    input  logic [7:0]        me_mv_y,
    input  logic [15:0]       me_sad
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_WAIT,
        S_ME_WAIT,
        S_ACK
    } state_t;

    state_t        r_state;
    logic          r_seq;
    logic          r_ack_tgl;
    logic          r_busy;
    logic          r_err;
    logic          r_upd;
    logic [3:0]    r_op;
    logic [31:0]   r_p1;
    logic [31:0]   r_p2;
    logic [31:0]   r_pend;
    logic [31:0]   r_res;
    logic [31:0]   r_me_cnt;
    logic [11:0]   r_key;
    logic [TW-1:0] r_wait;
    logic          r_we;
    logic          r_re;
    logic          r_start;

    logic w_accept;
    logic w_rv;
    logic w_done;
    logic w_abort;
    logic w_tmo;
    logic w_unused;

    assign w_accept = (r_state == S_IDLE) && (param3_in[31] != r_seq);
    // a response in the same cycle as our own strobe is not a real reply
    assign w_rv     = mem_rvalid && !r_re;
    assign w_done   = me_done && !r_start;
    assign w_abort  = key_sw_in[11];
    assign w_tmo    = (r_wait == TW'(TIMEOUT_CYCLES - 1));
    assign w_unused = ^param3_in[30:4];

    assign mem_addr  = r_p1[ADDR_W-1:0];
    assign mem_wdata = r_p2;
    assign mem_we    = r_we;
    assign mem_re    = r_re;
    assign me_start  = r_start;
    assign me_blk_x  = r_p1[15:0];
    assign me_blk_y  = r_p1[31:16];
    assign me_range  = r_p2[7:0];
    assign ledr_out  = {r_busy, r_err, r_ack_tgl, r_op, 13'd0, r_key, r_res};

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state   <= S_IDLE;
            r_seq     <= param3_in[31];
            r_ack_tgl <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_upd     <= 1'b0;
            r_op      <= 4'd0;
            r_p1      <= 32'd0;
            r_p2      <= 32'd0;
            r_pend    <= 32'd0;
            r_res     <= 32'd0;
            r_me_cnt  <= 32'd0;
            r_key     <= 12'd0;
            r_wait    <= '0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_start   <= 1'b0;
        end else begin
            r_key   <= key_sw_in;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_start <= 1'b0;
            // inclusive start..done count; the start cycle is preloaded as 1
            if (r_state == S_ME_WAIT && !r_start && r_me_cnt != 32'hFFFF_FFFF)
                r_me_cnt <= r_me_cnt + 32'd1;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_seq  <= param3_in[31];
                        r_p1   <= param1_in;
                        r_p2   <= param2_in;
                        r_op   <= param3_in[3:0];
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        r_upd  <= 1'b0;
                        r_wait <= '0;
                        case (param3_in[3:0])
                            4'd1: begin
                                r_we    <= 1'b1;
                                r_pend  <= param2_in;
                                r_upd   <= 1'b1;
                                r_state <= S_WR;
                            end
                            4'd2: begin
                                r_re    <= 1'b1;
                                r_state <= S_RD_WAIT;
                            end
                            4'd3: begin
                                r_start  <= 1'b1;
                                r_me_cnt <= 32'd1;
                                r_state  <= S_ME_WAIT;
                            end
                            4'd4: begin
                                r_pend  <= r_me_cnt;
                                r_upd   <= 1'b1;
                                r_state <= S_ACK;
                            end
                            default: begin
                                r_err   <= 1'b1;
                                r_state <= S_ACK;
                            end
                        endcase
                    end
                end
                S_WR: r_state <= S_ACK;
                S_RD_WAIT: begin
                    if (w_rv) begin
                        r_pend  <= mem_rdata;
                        r_upd   <= 1'b1;
                        r_state <= S_ACK;
                    end else if (w_abort) begin
                        r_err   <= 1'b1;
                        r_state <= S_ACK;
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_pend  <= 32'hFFFF_FFFF;
                        r_upd   <= 1'b1;
                        r_state <= S_ACK;
                    end else begin
                        r_wait <= r_wait + TW'(1);
                    end
                end
                S_ME_WAIT: begin
                    if (w_done) begin
                        r_pend  <= {me_sad, me_mv_y, me_mv_x};
                        r_upd   <= 1'b1;
                        r_state <= S_ACK;
                    end else if (w_abort) begin
                        r_err   <= 1'b1;
                        r_state <= S_ACK;
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_pend  <= 32'hFFFF_FFFF;
                        r_upd   <= 1'b1;
                        r_state <= S_ACK;
                    end else begin
                        r_wait <= r_wait + TW'(1);
                    end
                end
                S_ACK: begin
                    if (r_upd)
                        r_res <= r_pend;
                    r_ack_tgl <= r_seq;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_me_host_cmd_bridge.sv
// Scoreboard bench for me_host_cmd_bridge: driver pushes expected ACKs,
// a monitor pops them whenever the ack toggle on ledr_out[61] flips.
module tb_me_host_cmd_bridge;
    localparam int ADDR_W = 16;
    localparam int TMO    = 200;

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic [31:0]       param1_in, param2_in, param3_in;
    logic [11:0]       key_sw_in;
    logic [63:0]       ledr_out;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we, mem_re;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;
    logic              me_start;
    logic [15:0]       me_blk_x, me_blk_y;
    logic [7:0]        me_range;
    logic              me_done;
    logic [7:0]        me_mv_x, me_mv_y;
    logic [15:0]       me_sad;

    me_host_cmd_bridge #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .param1_in(param1_in), .param2_in(param2_in), .param3_in(param3_in),
        .key_sw_in(key_sw_in), .ledr_out(ledr_out),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .me_start(me_start), .me_blk_x(me_blk_x), .me_blk_y(me_blk_y),
        .me_range(me_range), .me_done(me_done), .me_mv_x(me_mv_x),
        .me_mv_y(me_mv_y), .me_sad(me_sad)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct packed {
        logic [31:0] res;
        logic        err;
        logic [3:0]  op;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic        tgl = 1'b0;
    bit          in_rst = 1'b1;
    logic [31:0] m_res = 32'd0;
    logic [31:0] m_run = 32'd0;
    logic [31:0] mem_m [int];
    int          wr_addrs[$];

    function automatic exp_t mk(logic [31:0] r, logic e, logic [3:0] o);
        exp_t x;
        x.res = r;
        x.err = e;
        x.op  = o;
        return x;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic flip(logic [31:0] p1, logic [31:0] p2, logic [3:0] op);
        param1_in = p1;
        param2_in = p2;
        tgl       = ~tgl;
        param3_in = {tgl, 27'($urandom), op};
    endtask

    task automatic wait_ack(string name);
        int k;
        k = 0;
        while (!(ledr_out[61] === tgl && ledr_out[63] === 1'b0) && k < 2000) begin
            @(negedge clk_clk);
            k++;
        end
        if (k >= 2000) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_ack_wait: ack=%b busy=%b, expected ack=%b busy=0",
                     name, ledr_out[61], ledr_out[63], tgl);
        end
    endtask

    task automatic wait_strobe(string name, int which);
        int   k;
        logic s;
        k = 0;
        do begin
            @(negedge clk_clk);
            k++;
            s = (which != 0) ? me_start : mem_re;
        end while (s !== 1'b1 && k < 50);
        if (k >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: strobe=%b, expected 1 within 50 cycles", name, s);
        end
    endtask

    // monitor: pops one expectation per observed ack-toggle flip
    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk_clk);
            if (in_rst || reset_reset) begin
                prev = ledr_out[61];
            end else if (ledr_out[61] !== prev) begin
                prev = ledr_out[61];
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got ack with empty scoreboard, result 0x%0h",
                             ledr_out[31:0]);
                end else begin
                    e = sb.pop_front();
                    chk("ack_result", ledr_out[31:0], e.res);
                    chk("ack_error", ledr_out[62], e.err);
                    chk("ack_opcode", ledr_out[60:57], e.op);
                    chk("ack_busy", ledr_out[63], 1'b0);
                end
            end
        end
    end

    task automatic do_write(logic [ADDR_W-1:0] a, logic [31:0] d, bit timed);
        flip({16'($urandom), a}, d, 4'd1);
        sb.push_back(mk(d, 1'b0, 4'd1));
        m_res = d;
        mem_m[int'(a)] = d;
        wr_addrs.push_back(int'(a));
        @(negedge clk_clk);
        chk("wr_we", mem_we, 1'b1);
        chk("wr_addr", mem_addr, a);
        chk("wr_data", mem_wdata, d);
        @(negedge clk_clk);
        chk("wr_we_width", mem_we, 1'b0);
        if (timed) begin
            @(negedge clk_clk);
            chk("wr_latency_result", ledr_out[31:0], d);
            chk("wr_latency_ack", ledr_out[61], tgl);
        end
        wait_ack("wr");
    endtask

    task automatic do_read(logic [ADDR_W-1:0] a, logic [31:0] d, int dly);
        flip({16'($urandom), a}, $urandom, 4'd2);
        sb.push_back(mk(d, 1'b0, 4'd2));
        m_res = d;
        wait_strobe("rd_strobe", 0);
        chk("rd_addr", mem_addr, a);
        @(negedge clk_clk);
        chk("rd_re_width", mem_re, 1'b0);
        cyc(dly - 1);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        @(negedge clk_clk);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        wait_ack("rd");
    endtask

    task automatic do_run(logic [31:0] p1, logic [7:0] rng, int dly,
                          logic [7:0] mx, logic [7:0] my, logic [15:0] sad);
        flip(p1, {24'($urandom), rng}, 4'd3);
        sb.push_back(mk({sad, my, mx}, 1'b0, 4'd3));
        m_res = {sad, my, mx};
        m_run = 32'(dly + 1);
        wait_strobe("run_start", 1);
        chk("run_blk_x", me_blk_x, p1[15:0]);
        chk("run_blk_y", me_blk_y, p1[31:16]);
        chk("run_range", me_range, rng);
        cyc(dly);
        me_done = 1'b1;
        me_mv_x = mx;
        me_mv_y = my;
        me_sad  = sad;
        @(negedge clk_clk);
        me_done = 1'b0;
        wait_ack("run");
    endtask

    task automatic do_status();
        flip($urandom, $urandom, 4'd4);
        sb.push_back(mk(m_run, 1'b0, 4'd4));
        m_res = m_run;
        wait_ack("status");
    endtask

    task automatic do_bad(logic [3:0] op);
        flip($urandom, $urandom, op);
        sb.push_back(mk(m_res, 1'b1, op));
        wait_ack("bad_op");
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int          kind, strobes, a;
        logic [3:0]  bop;
        logic [15:0] pw_a;
        logic [31:0] pw_d;

        reset_reset = 1'b1;
        param1_in   = 32'd0;
        param2_in   = 32'd0;
        param3_in   = 32'd0;
        key_sw_in   = 12'd0;
        mem_rdata   = 32'd0;
        mem_rvalid  = 1'b0;
        me_done     = 1'b0;
        me_mv_x     = 8'd0;
        me_mv_y     = 8'd0;
        me_sad      = 16'd0;
        cyc(3);
        chk("rst_ledr", ledr_out, 64'd0);
        chk("rst_strobes", {mem_we, mem_re, me_start}, 3'b000);
        chk("rst_mem_addr", mem_addr, 16'd0);
        chk("rst_blk", {me_blk_x, me_blk_y, me_range}, 40'd0);
        reset_reset = 1'b0;
        @(negedge clk_clk);
        in_rst = 1'b0;

        do_write(16'h0010, 32'hCAFE_F00D, 1'b1);
        do_read(16'h0010, 32'h1234_5678, 5);
        mem_m[16] = 32'h1234_5678;
        do_run(32'h0020_0010, 8'd8, 100, 8'hFD, 8'h02, 16'h01F4);
        chk("run_packed", m_res, 32'h01F4_02FD);
        do_status();

        flip(32'h0000_0077, $urandom, 4'd2);
        sb.push_back(mk(32'hFFFF_FFFF, 1'b1, 4'd2));
        m_res = 32'hFFFF_FFFF;
        wait_ack("timeout");
        do_bad(4'd0);
        do_bad(4'd9);
        do_write(16'h0042, 32'h0BAD_BEEF, 1'b0);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 5);
            key_sw_in = {1'b0, 11'($urandom)};
            @(negedge clk_clk);
            chk("key_echo", ledr_out[43:32], key_sw_in);
            chk("zero_field", ledr_out[56:44], 13'd0);
            if (kind == 1 && wr_addrs.size() != 0) begin
                a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
                do_read(16'(a), mem_m[a], $urandom_range(1, 20));
            end else if (kind == 2) begin
                do_run($urandom, 8'($urandom), $urandom_range(1, 60),
                       8'($urandom), 8'($urandom), 16'($urandom));
            end else if (kind == 3) begin
                do_status();
            end else if (kind == 4) begin
                bop = 4'($urandom_range(5, 16));
                do_bad(bop);
            end else begin
                do_write(16'($urandom), $urandom, 1'b0);
            end
        end
        key_sw_in = 12'd0;

        flip(32'h0003_0004, 32'd4, 4'd3);
        sb.push_back(mk(m_res, 1'b1, 4'd3));
        wait_strobe("abort_start", 1);
        cyc(5);
        key_sw_in[11] = 1'b1;
        pw_a = 16'h0ABC;
        pw_d = $urandom;
        flip({16'd0, pw_a}, pw_d, 4'd1);
        sb.push_back(mk(pw_d, 1'b0, 4'd1));
        m_res = pw_d;
        @(negedge clk_clk);
        key_sw_in[11] = 1'b0;
        me_done = 1'b1;
        me_mv_x = 8'h55;
        me_mv_y = 8'h66;
        me_sad  = 16'h7777;
        @(negedge clk_clk);
        me_done = 1'b0;
        @(negedge clk_clk);
        chk("pending_we", mem_we, 1'b1);
        chk("pending_addr", mem_addr, pw_a);
        wait_ack("pending");

        flip(32'h0040_0030, 32'd16, 4'd3);
        wait_strobe("rst_run_start", 1);
        in_rst = 1'b1;
        reset_reset = 1'b1;
        sb.delete();
        @(negedge clk_clk);
        chk("midrun_ledr", ledr_out, 64'd0);
        chk("midrun_strobes", {mem_we, mem_re, me_start}, 3'b000);
        chk("midrun_blk", {me_blk_x, me_blk_y, me_range}, 40'd0);
        chk("midrun_mem", {mem_addr, mem_wdata}, 48'd0);
        tgl = 1'b1;
        param3_in = {1'b1, 27'd0, 4'd1};
        @(negedge clk_clk);
        reset_reset = 1'b0;
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_clk);
            strobes += int'(mem_we) + int'(mem_re) + int'(me_start);
        end
        chk("rst_toggle_no_strobe", strobes, 0);
        chk("rst_toggle_idle", ledr_out[63], 1'b0);

        reset_reset = 1'b1;
        tgl = 1'b0;
        param3_in = 32'd0;
        cyc(2);
        reset_reset = 1'b0;
        @(negedge clk_clk);
        in_rst = 1'b0;
        m_res = 32'd0;
        m_run = 32'd0;
        do_status();

        cyc(5);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
